seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumes the 16-bit output port produced by the memory-mapped output driver.
- Time-multiplexes the port value onto a 4-digit common-anode seven-segment display as hex digits 0-F.
- Samples the port only at frame boundaries, so a mid-scan CPU write never tears the displayed value.
- Sits between the output driver and the board pins.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Must be >= 4.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off (ghosting guard). Must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- IO_port  input  16  value to display. Nibble n goes to digit n; digit 0 is the rightmost.
- enable  input  1  scan enable. 0 blanks the display and freezes the scan.
- an  output  4  anode selects, active-low, one-hot-low when lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset is asynchronous, active-high, single clock domain. While reset is asserted:
  - prescaler = 0, digit = 0, shadow = 16'h0000
  - an = 4'b1111, seg = 7'b1111111, frame_done = 0
- Prescaler counts 0..REFRESH_DIV-1 while enable=1, then wraps to 0.
- At the terminal count the digit index advances 0->1->2->3->0.
- On the 3->0 wrap, in the same clock edge:
  - shadow <= IO_port
  - frame_done pulses high for exactly one cycle
- No other event loads shadow. After reset the display shows 0000 until the first frame completes.
- Hex decode (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Output register stage: an and seg are registered, 1 cycle behind the prescaler/digit state.
  - Prescaler < BLANK_CYCLES: an=1111, seg=1111111.
  - Otherwise: an[digit]=0 (other anodes 1), seg = decode(shadow[4*digit+3 : 4*digit]).
- enable=0: prescaler, digit and shadow hold. Next cycle an=1111, seg=1111111, and frame_done stays 0.
- enable re-asserted: counting resumes from the held prescaler/digit; no slot restart.
- IO_port changes mid-frame: ignored until the next 3->0 wrap.
- Reset asserted mid-slot: outputs blank immediately (asynchronous). On release the scan restarts at digit 0, prescaler 0.
- Prescaler width = clog2(REFRESH_DIV). No overflow beyond REFRESH_DIV-1.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k = 3..1) is blanked (seg=1111111, anode still off) when shadow nibble k and every higher nibble are 0.
  - Digit 0 is always shown. Example: shadow 16'h0040 lights digits 1 ("4") and 0 ("0") only.
  - Blanking is evaluated from shadow, so it changes only at frame boundaries.
- Not defined: all four digits are always shown, including leading zeros.

Test Plan:
Bench configuration: REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset release with IO_port=16'h1234, enable=1.
   - Cycles 0-31: every lit slot shows seg=1000000.
   - frame_done pulses once, at cycle 31.
   - Next frame: an=1110 with seg=0011001 ("4"), then an=1101 with seg=0110000 ("3"), then "2", then "1".
2. IO_port changes 1234 -> ABCD at mid-frame cycle 45.
   - Rest of the frame still shows 1234 digits.
   - After the wrap at cycle 63: digit0=0100001 ("d"), digit3=0001000 ("A").
3. Blank window: in every slot, the registered outputs for prescaler=0 and 1 are an=1111.
   - an goes low exactly 3 cycles after slot start (BLANK_CYCLES + 1 register stage).
4. enable=0 for 20 cycles mid-slot of digit 2.
   - Outputs are blank 1 cycle later; prescaler and digit are frozen; no frame_done.
   - After re-enable: digit 2 resumes for its remaining cycles, then digit 3.
5. Reset asserted asynchronously between clock edges mid-frame.
   - an=1111 and seg=1111111 immediately.
   - After release: first lit anode is an=1110, shadow=0.
6. With SEG7_LZB_EN defined, IO_port=16'h0000 and then 16'h0F00.
   - 0000: only digit 0 lights, showing "0".
   - 0F00: digits 2..0 light ("F00"); digit 3 stays dark for the whole slot.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexes a 16-bit value onto a 4-digit common-anode
//               seven-segment display as hex digits 0-F. The value is latched
//               into a shadow register only when the scan wraps from digit 3
//               back to digit 0, so a CPU write part-way through a frame
//               cannot tear the displayed number.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : REFRESH_DIV  - clock cycles per digit slot (>= 4)
//               BLANK_CYCLES - all-anodes-off cycles at slot start
//                              (< REFRESH_DIV)
// Ports       : clk        in   system clock, rising edge
//               reset      in   asynchronous, active-high
//               IO_port    in   [15:0] value; nibble n -> digit n (0 = right)
//               enable     in   scan enable; 0 blanks and freezes the scan
//               an         out  [3:0] anode selects, active-low
//               seg        out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//               frame_done out  one-cycle pulse on the digit 3 -> 0 wrap
// Options     : `define SEG7_LZB_EN enables leading-zero blanking of
//               digits 3..1 (digit 0 is always shown).
// ============================================================================
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IO_port,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int            PW      = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] C_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] C_BLANK = PW'(BLANK_CYCLES);
    localparam logic [PW-1:0] C_ONE   = PW'(1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit;
    logic [15:0]   r_shadow;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_frame_done;

    logic          w_tc;
    logic          w_wrap;
    logic [3:0]    w_nib;
    logic [6:0]    w_decode;
    logic          w_lz_blank;
    logic          w_dark;

    assign w_tc   = (r_presc == C_LAST);
    assign w_wrap = w_tc && (r_digit == 2'd3);

    // ------------------------------------------------------------------
    // Scan state: prescaler, digit index and frame-boundary shadow load
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_digit  <= 2'd0;
            r_shadow <= 16'h0000;
        end else if (enable) begin
            if (w_tc) begin
                r_presc <= '0;
                r_digit <= r_digit + 2'd1;
            end else begin
                r_presc <= r_presc + C_ONE;
            end
            if (w_wrap) begin
                r_shadow <= IO_port;
            end
        end
    end

    // ------------------------------------------------------------------
    // Nibble select and hex decode (active-low gfedcba)
    // ------------------------------------------------------------------
    assign w_nib = r_shadow[{r_digit, 2'b00} +: 4];

    always_comb begin
        w_decode = 7'b1111111;
        case (w_nib)
            4'h0: w_decode = 7'b1000000;
            4'h1: w_decode = 7'b1111001;
            4'h2: w_decode = 7'b0100100;
            4'h3: w_decode = 7'b0110000;
            4'h4: w_decode = 7'b0011001;
            4'h5: w_decode = 7'b0010010;
            4'h6: w_decode = 7'b0000010;
            4'h7: w_decode = 7'b1111000;
            4'h8: w_decode = 7'b0000000;
            4'h9: w_decode = 7'b0010000;
            4'hA: w_decode = 7'b0001000;
            4'hB: w_decode = 7'b0000011;
            4'hC: w_decode = 7'b1000110;
            4'hD: w_decode = 7'b0100001;
            4'hE: w_decode = 7'b0000110;
            default: w_decode = 7'b0001110;
        endcase
    end

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every higher nibble are zero.
    // Digit 0 is never blanked so a zero value still shows "0".
    always_comb begin
        w_lz_blank = 1'b0;
        case (r_digit)
            2'd3:    w_lz_blank = (r_shadow[15:12] == 4'h0);
            2'd2:    w_lz_blank = (r_shadow[15:8]  == 8'h00);
            2'd1:    w_lz_blank = (r_shadow[15:4]  == 12'h000);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // Dark when disabled, inside the ghosting guard, or a blanked leading zero
    assign w_dark = !enable || (r_presc < C_BLANK) || w_lz_blank;

    // ------------------------------------------------------------------
    // Output register stage (one cycle behind the scan state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= enable && w_wrap;
            if (w_dark) begin
                r_an  <= 4'b1111;
                r_seg <= 7'b1111111;
            end else begin
                r_an  <= ~(4'b0001 << r_digit);
                r_seg <= w_decode;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with
//               REFRESH_DIV=8, BLANK_CYCLES=2. Outputs are sampled on the
//               falling clock edge; inputs are driven there as well.
//               Expectations follow SEG7_LZB_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // Hand-written active-low segment codes for the digits used
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic        clk;
    logic        reset;
    logic [15:0] IO_port;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int checks;
    int fails;

    seg7_scan_driver #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .IO_port   (IO_port),
        .enable    (enable),
        .an        (an),
        .seg       (seg),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] anode(input int d);
        case (d)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Compare {frame_done, an, seg} against the expected value
    task automatic chk(input string tag, input logic [11:0] exp_v);
        logic [11:0] obs;
        obs = {frame_done, an, seg};
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed fd/an/seg=%03h expected %03h", tag, obs, exp_v);
        end
    endtask

    // One full slot as seen on the registered outputs: two dark cycles,
    // six lit cycles, and frame_done on the last cycle of the digit-3 slot.
    task automatic check_slot(input string tag, input int d,
                              input logic [6:0] segv, input bit lit);
        logic        exp_fd;
        logic [11:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_fd = (d == 3) && (i == 7);
            if (i >= 2 && lit)
                exp_v = {exp_fd, anode(d), segv};
            else
                exp_v = {exp_fd, 4'b1111, SOFF};
            chk(tag, exp_v);
        end
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        reset   = 1'b1;
        enable  = 1'b1;
        IO_port = 16'h1234;

        // Reset state
        step();
        step();
        chk("reset_state", {1'b0, 4'b1111, SOFF});
        reset = 1'b0;
        chk("cycle0_blank", {1'b0, 4'b1111, SOFF});

        // Frame 1: shadow still zero
        check_slot("f1_d0", 0, S0, 1'b1);
        check_slot("f1_d1", 1, S0, !LZB);
        check_slot("f1_d2", 2, S0, !LZB);
        check_slot("f1_d3", 3, S0, !LZB);

        // Frame 2: shows 1234; IO_port changes mid-frame and is ignored
        check_slot("f2_d0", 0, S4, 1'b1);
        IO_port = 16'hABCD;
        check_slot("f2_d1", 1, S3, 1'b1);
        check_slot("f2_d2", 2, S2, 1'b1);
        check_slot("f2_d3", 3, S1, 1'b1);

        // Frame 3: new value ABCD
        check_slot("f3_d0", 0, SD, 1'b1);
        check_slot("f3_d1", 1, SC, 1'b1);
        check_slot("f3_d2", 2, SB, 1'b1);
        check_slot("f3_d3", 3, SA, 1'b1);

        // Frame 4: disable mid-slot of digit 2
        check_slot("f4_d0", 0, SD, 1'b1);
        check_slot("f4_d1", 1, SC, 1'b1);
        step(); chk("f4_d2_pre0", {1'b0, 4'b1111, SOFF});
        step(); chk("f4_d2_pre1", {1'b0, 4'b1111, SOFF});
        step(); chk("f4_d2_pre2", {1'b0, 4'b1011, SB});
        step(); chk("f4_d2_pre3", {1'b0, 4'b1011, SB});
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("disabled_blank", {1'b0, 4'b1111, SOFF});
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("f4_d2_resume", {1'b0, 4'b1011, SB});
        end
        check_slot("f4_d3", 3, SA, 1'b1);

        // Frame 5: asynchronous reset between clock edges
        check_slot("f5_d0", 0, SD, 1'b1);
        step(); chk("f5_d1_0", {1'b0, 4'b1111, SOFF});
        step(); chk("f5_d1_1", {1'b0, 4'b1111, SOFF});
        step(); chk("f5_d1_2", {1'b0, 4'b1101, SC});
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {1'b0, 4'b1111, SOFF});
        IO_port = 16'h0000;
        step();
        step();
        chk("reset_held", {1'b0, 4'b1111, SOFF});
        reset = 1'b0;
        chk("rst_cycle0", {1'b0, 4'b1111, SOFF});

        // After release: shadow is zero again, scan restarts at digit 0
        check_slot("z1_d0", 0, S0, 1'b1);
        check_slot("z1_d1", 1, S0, !LZB);
        check_slot("z1_d2", 2, S0, !LZB);
        check_slot("z1_d3", 3, S0, !LZB);

        // Shadow 0000 loaded explicitly
        check_slot("z2_d0", 0, S0, 1'b1);
        IO_port = 16'h0F00;
        check_slot("z2_d1", 1, S0, !LZB);
        check_slot("z2_d2", 2, S0, !LZB);
        check_slot("z2_d3", 3, S0, !LZB);

        // Shadow 0F00: digit 3 is the only leading zero
        check_slot("f0f_d0", 0, S0, 1'b1);
        check_slot("f0f_d1", 1, S0, 1'b1);
        check_slot("f0f_d2", 2, SF, 1'b1);
        check_slot("f0f_d3", 3, S0, !LZB);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
